// File: rtl/serial_word_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_rx_if
// Purpose  : Bundles the serial input side (in_valid/start/A/sel) and the
//            parallel valid/ready output side of serial_word_rx.
// Ports    : master - producer of serial bits and consumer of words
//                     (drives in_valid, start, A, sel, out_ready)
//            slave  - the receiver (drives out_data, out_valid, neg_ovf,
//                     overrun)
// Revision : 1.0 - initial release
// ============================================================================
interface serial_word_rx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             start;
  logic             A;
  logic             sel;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             neg_ovf;
  logic             overrun;

  modport master (
    output in_valid, start, A, sel, out_ready,
    input  out_data, out_valid, neg_ovf, overrun
  );

  modport slave (
    input  in_valid, start, A, sel, out_ready,
    output out_data, out_valid, neg_ovf, overrun
  );
endinterface
`default_nettype wire

// File: rtl/serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_rx
// Purpose  : Receives a WIDTH-bit frame LSB first, one bit per accepted
//            cycle, optionally two's-complementing it on the fly, and offers
//            the assembled word on a valid/ready handshake.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - serial_word_rx_if.slave:
//                   in_valid/start/A/sel  serial input (sel sampled with start)
//                   out_ready             downstream accepts the word
//                   out_data/out_valid    assembled word and its valid
//                   neg_ovf               most-negative value was negated
//                   overrun               sticky: bit arrived while word held
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_rx #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_word_rx_if.slave bus
);

  // Bit counter only ever holds 0..WIDTH-1: the WIDTH-th bit completes the
  // frame and resets it, so $clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             neg_q,   neg_d;
  logic             ovr_q,   ovr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             seen_q,  seen_d;
  logic             sel_q,   sel_d;

  // Per-cycle decode of what happens to the incoming bit.
  logic take_start;   // bit is accepted as bit 0 of a new frame
  logic take_bit;     // bit is accepted as a continuation bit
  logic eff_sel;      // sel in force for this bit
  logic eff_seen;     // "a 1 was already seen" in force for this bit
  logic bit_b;        // transformed bit shifted into the word

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
      ovr_q   <= 1'b0;
      count_q <= '0;
      seen_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      neg_q   <= neg_d;
      ovr_q   <= ovr_d;
      count_q <= count_d;
      seen_q  <= seen_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    neg_d      = neg_q;
    ovr_d      = ovr_q;
    count_d    = count_q;
    seen_d     = seen_q;
    sel_d      = sel_q;
    take_start = 1'b0;
    take_bit   = 1'b0;

    case (state_q)
      IDLE: begin
        // Stray bits without a start marker are silently ignored.
        if (bus.in_valid && bus.start) begin
          take_start = 1'b1;
        end
      end

      SHIFT: begin
        // A start mid-frame abandons the partial frame; the stale bits in
        // data_q are flushed by the WIDTH shifts of the new frame.
        if (bus.in_valid) begin
          if (bus.start) begin
            take_start = 1'b1;
          end else begin
            take_bit = 1'b1;
          end
        end
      end

      HOLD: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          neg_d   = 1'b0;
          state_d = IDLE;
          // Zero-bubble: a start on the handshake edge opens the next frame.
          if (bus.in_valid && bus.start) begin
            take_start = 1'b1;
          end
        end else if (bus.in_valid) begin
          ovr_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Serial two's complement: copy bits up to and including the first 1,
    // invert every bit after it. The start bit always sees an empty history.
    eff_sel  = take_start ? bus.sel : sel_q;
    eff_seen = take_start ? 1'b0    : seen_q;
    bit_b    = (eff_sel && eff_seen) ? ~bus.A : bus.A;

    if (take_start || take_bit) begin
      data_d = {bit_b, data_q[WIDTH-1:1]};
      seen_d = eff_seen | bus.A;
    end

    if (take_start) begin
      sel_d   = bus.sel;
      count_d = CW'(1);
      state_d = SHIFT;
    end

    if (take_bit) begin
      if (count_q == LAST_IDX) begin
        state_d = HOLD;
        valid_d = 1'b1;
        count_d = '0;
        // seen_q here covers bits 0..WIDTH-2 exactly, so no 1 before and a
        // 1 now means the raw frame was the most-negative value.
        neg_d   = sel_q & ~seen_q & bus.A;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.neg_ovf   = neg_q;
  assign bus.overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_rx
// Purpose  : Directed bench for serial_word_rx (WIDTH=8) with a word-level
//            reference model checked every cycle plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_rx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  serial_word_rx_if #(.WIDTH(W)) bus ();

  serial_word_rx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- word-level reference model ----------------
  // Collects raw bits into an integer and applies the transform as a plain
  // arithmetic negation once the frame is complete.
  bit           m_ok = 1'b0;
  bit           m_col, m_sel, m_valid, m_neg, m_ovr;
  int           m_n;
  logic [W-1:0] m_raw, m_word;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_col = 1'b0; m_n = 0; m_sel = 1'b0; m_raw = '0;
      m_valid = 1'b0; m_word = '0; m_neg = 1'b0; m_ovr = 1'b0;
    end else if (m_ok) begin
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid = 1'b0;
          m_neg   = 1'b0;
          if (bus.in_valid && bus.start) begin
            m_col = 1'b1; m_raw = '0; m_raw[0] = bus.A; m_n = 1; m_sel = bus.sel;
          end
        end else if (bus.in_valid) begin
          m_ovr = 1'b1;
        end
      end else if (bus.in_valid) begin
        if (bus.start) begin
          m_col = 1'b1; m_raw = '0; m_raw[0] = bus.A; m_n = 1; m_sel = bus.sel;
        end else if (m_col) begin
          m_raw[m_n] = bus.A;
          m_n++;
          if (m_n == W) begin
            m_col   = 1'b0;
            m_valid = 1'b1;
            m_word  = m_sel ? (~m_raw + 1'b1) : m_raw;
            m_neg   = m_sel && (m_raw == (1 << (W - 1)));
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [W-1:0] got_q[$];
  bit           neg_q[$];
  int           hs_q[$];
  int           rise_q[$];
  int           cyc = 0;
  bit           prev_v = 1'b0;

  always @(negedge clk) begin
    if (m_ok && !rst) begin
      cyc++;
      chk("out_valid", bus.out_valid, m_valid);
      chk("overrun", bus.overrun, m_ovr);
      if (m_valid) begin
        chk("out_data", bus.out_data, m_word);
        chk("neg_ovf", bus.neg_ovf, m_neg);
        if (!prev_v) rise_q.push_back(cyc);
        if (bus.out_ready) begin
          got_q.push_back(bus.out_data);
          neg_q.push_back(bus.neg_ovf);
          hs_q.push_back(cyc);
        end
      end
      prev_v = m_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit st, input bit a, input bit s);
    bus.in_valid = v; bus.start = st; bus.A = a; bus.sel = s;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] v, input bit s, input bit gap);
    for (int i = 0; i < W; i++) begin
      drive(1'b1, i == 0, v[i], s);
      if (gap) idle(1);
    end
  endtask

  logic [W-1:0] exp_words [9] = '{8'h35, 8'hFA, 8'h00, 8'h80, 8'hFA, 8'h0F, 8'hA5, 8'hC3, 8'hFF};
  bit           exp_negs  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.A = 1'b0; bus.sel = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_data", bus.out_data, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset neg_ovf", bus.neg_ovf, 0);
    chk("reset overrun", bus.overrun, 0);
    rst = 1'b0;
    idle(2);

    // Plain frame.
    send(8'h35, 1'b0, 1'b0);
    idle(3);

    // Back-to-back complemented frames, including the most-negative value.
    send(8'h06, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'h80, 1'b1, 1'b0);
    idle(3);

    // Stalled output with two stray bits while holding.
    bus.out_ready = 1'b0;
    send(8'h06, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("stall out_data", bus.out_data, 8'hFA);
    chk("stall overrun", bus.overrun, 1);
    bus.out_ready = 1'b1;
    idle(3);
    chk("overrun sticky", bus.overrun, 1);

    // Aborted frame restarted by a new start, then gapped delivery.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    send(8'h0F, 1'b0, 1'b1);
    idle(3);

    // Reset mid-frame, then a clean frame.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    chk("midreset out_data", bus.out_data, 0);
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset overrun", bus.overrun, 0);
    rst = 1'b0;
    send(8'hA5, 1'b0, 1'b0);
    idle(3);
    chk("after reset overrun", bus.overrun, 0);

    // Zero-bubble back-to-back pair.
    send(8'hC3, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    idle(3);

    // Literal pins on the captured words and handshake timing.
    chk("word count", got_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("word[%0d]", i), got_q[i], exp_words[i]);
        chk($sformatf("neg[%0d]", i), neg_q[i], exp_negs[i]);
      end
    end
    if (rise_q.size() >= 9 && hs_q.size() >= 9) begin
      chk("b2b gap 0xFA->0x00", rise_q[2] - hs_q[1], W);
      chk("b2b gap 0xC3->0xFF", rise_q[8] - hs_q[7], W);
    end else begin
      chk("handshake records", rise_q.size() + hs_q.size(), 18);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
